// File: rtl/fproc_core_req.sv
// Core-side function-processor initiator: one request in flight, 2-cycle minimum accept-to-result latency.
// req_ready is high only in IDLE. The optional WAIT timeout is built when FPROC_TIMEOUT_EN is defined.
module fproc_core_req #(
  parameter int ID_WIDTH       = 8,
  parameter int DATA_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  req_valid,
  input  logic [ID_WIDTH-1:0]   req_id,
  output logic                  req_ready,
  output logic                  fproc_enable,
  output logic [ID_WIDTH-1:0]   fproc_id,
  input  logic                  fproc_ready,
  input  logic [DATA_WIDTH-1:0] fproc_data,
  output logic                  result_valid,
  output logic [DATA_WIDTH-1:0] result_data,
  output logic                  result_timeout,
  output logic [15:0]           last_wait
);

  if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
    $error("TIMEOUT_CYCLES must be >= 1");
  end

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t                  state_q, state_d;
  logic [ID_WIDTH-1:0]     id_q, id_d;
  logic                    fproc_enable_q, fproc_enable_d;
  logic                    result_valid_q, result_valid_d;
  logic [DATA_WIDTH-1:0]   result_data_q, result_data_d;
  logic                    result_timeout_q, result_timeout_d;
  logic [15:0]             wait_cnt_q, wait_cnt_d;
  logic [15:0]             last_wait_q, last_wait_d;
  logic                    accept;
  logic                    timeout_hit;

  assign req_ready = (state_q == S_IDLE) && !reset;
  assign accept    = req_valid && req_ready;

`ifdef FPROC_TIMEOUT_EN
  localparam logic [31:0] TO_LIM = 32'(TIMEOUT_CYCLES);
  // Saturated counter never reaches limits above 0xFFFF, so such a wait never times out.
  assign timeout_hit = (state_q == S_WAIT) && ({16'd0, wait_cnt_q} >= TO_LIM);
`else
  assign timeout_hit = 1'b0;
`endif

  always_comb begin
    state_d          = state_q;
    id_d             = id_q;
    fproc_enable_d   = 1'b0;
    result_valid_d   = 1'b0;
    result_data_d    = result_data_q;
    result_timeout_d = result_timeout_q;
    wait_cnt_d       = wait_cnt_q;
    last_wait_d      = last_wait_q;

    case (state_q)
      S_IDLE: begin
        if (accept) begin
          state_d        = S_ISSUE;
          id_d           = req_id;
          fproc_enable_d = 1'b1;
          wait_cnt_d     = 16'd0;
        end
      end

      S_ISSUE, S_WAIT: begin
        if (wait_cnt_q != 16'hFFFF) begin
          wait_cnt_d = wait_cnt_q + 16'd1;
        end
        // A response in the timeout cycle wins over the timeout.
        if (fproc_ready) begin
          state_d          = S_DONE;
          result_valid_d   = 1'b1;
          result_data_d    = fproc_data;
          result_timeout_d = 1'b0;
          last_wait_d      = wait_cnt_q;
        end else if (timeout_hit) begin
          state_d          = S_DONE;
          result_valid_d   = 1'b1;
          result_data_d    = '0;
          result_timeout_d = 1'b1;
          last_wait_d      = wait_cnt_q;
        end else begin
          state_d = S_WAIT;
        end
      end

      S_DONE: begin
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q          <= S_IDLE;
      id_q             <= '0;
      fproc_enable_q   <= 1'b0;
      result_valid_q   <= 1'b0;
      result_data_q    <= '0;
      result_timeout_q <= 1'b0;
      wait_cnt_q       <= 16'd0;
      last_wait_q      <= 16'd0;
    end else begin
      state_q          <= state_d;
      id_q             <= id_d;
      fproc_enable_q   <= fproc_enable_d;
      result_valid_q   <= result_valid_d;
      result_data_q    <= result_data_d;
      result_timeout_q <= result_timeout_d;
      wait_cnt_q       <= wait_cnt_d;
      last_wait_q      <= last_wait_d;
    end
  end

  assign fproc_enable   = fproc_enable_q;
  assign fproc_id       = id_q;
  assign result_valid   = result_valid_q;
  assign result_data    = result_data_q;
  assign result_timeout = result_timeout_q;
  assign last_wait      = last_wait_q;

endmodule

// File: tb/tb_fproc_core_req.sv
// Bench for fproc_core_req: directed scenarios plus randomized transactions against a latency/result model.
module tb_fproc_core_req;
  localparam int TMO = 4;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        req_valid = 1'b0;
  logic [7:0]  req_id = '0;
  logic        req_ready;
  logic        fproc_enable;
  logic [7:0]  fproc_id;
  logic        fproc_ready = 1'b0;
  logic [31:0] fproc_data = '0;
  logic        result_valid;
  logic [31:0] result_data;
  logic        result_timeout;
  logic [15:0] last_wait;

  int checks = 0;
  int failures = 0;

  fproc_core_req #(.ID_WIDTH(8), .DATA_WIDTH(32), .TIMEOUT_CYCLES(TMO)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_id(req_id), .req_ready(req_ready),
    .fproc_enable(fproc_enable), .fproc_id(fproc_id),
    .fproc_ready(fproc_ready), .fproc_data(fproc_data),
    .result_valid(result_valid), .result_data(result_data),
    .result_timeout(result_timeout), .last_wait(last_wait)
  );

  always #5 clk = ~clk;

  // One transaction; the responder answers k cycles after the ISSUE cycle (k=0: answer in ISSUE).
  // Model: result appears accept+2+k, or accept+2+TMO with timeout when k exceeds TMO.
  task automatic run_txn(input logic [7:0] id, input int k, input logic [31:0] dat, input bit spur, input string tag);
    int d; bit exp_to; logic [31:0] exp_dat; logic [15:0] exp_lw;
    int n_en, en_cyc, n_res, res_cyc; bit rdy_bad, rdy_back;
    logic [7:0] en_id; logic [31:0] got_dat; logic got_to; logic [15:0] got_lw;
    n_en = 0; en_cyc = 0; n_res = 0; res_cyc = 0; rdy_bad = 0; rdy_back = 0;
    en_id = '0; got_dat = '0; got_to = 1'b0; got_lw = '0;
    d = 2 + k; exp_to = 1'b0; exp_dat = dat; exp_lw = 16'(k);
`ifdef FPROC_TIMEOUT_EN
    if (k > TMO) begin d = 2 + TMO; exp_to = 1'b1; exp_dat = '0; exp_lw = 16'(TMO); end
`endif
    @(negedge clk);
    req_valid = 1'b1; req_id = id;
    @(negedge clk);
    req_valid = 1'b0; req_id = 8'($urandom);
    for (int c = 1; c <= d + 1; c++) begin
      if (fproc_enable) begin n_en++; en_cyc = c; en_id = fproc_id; end
      if (result_valid) begin
        n_res++; res_cyc = c; got_dat = result_data; got_to = result_timeout; got_lw = last_wait;
      end
      if (c <= d && req_ready) rdy_bad = 1'b1;
      if (c == d + 1) rdy_back = req_ready;
      fproc_ready = (c == k + 1) || (spur && c > 1);
      fproc_data  = (c == k + 1) ? dat : $urandom;
      @(negedge clk);
    end
    fproc_ready = 1'b0;
    checks++; if (n_en !== 1 || en_cyc !== 1) begin failures++; $display("FAIL %s enable: pulses=%0d at=%0d want 1 at 1", tag, n_en, en_cyc); end
    checks++; if (en_id !== id) begin failures++; $display("FAIL %s fproc_id: got %0h want %0h", tag, en_id, id); end
    checks++; if (n_res !== 1 || res_cyc !== d) begin failures++; $display("FAIL %s result_valid: pulses=%0d at=%0d want 1 at %0d", tag, n_res, res_cyc, d); end
    checks++; if (got_dat !== exp_dat) begin failures++; $display("FAIL %s result_data: got %0h want %0h", tag, got_dat, exp_dat); end
    checks++; if (got_to !== exp_to) begin failures++; $display("FAIL %s result_timeout: got %0b want %0b", tag, got_to, exp_to); end
    checks++; if (got_lw !== exp_lw) begin failures++; $display("FAIL %s last_wait: got %0d want %0d", tag, got_lw, exp_lw); end
    checks++; if (rdy_bad !== 1'b0 || rdy_back !== 1'b1) begin failures++; $display("FAIL %s req_ready: high_in_txn=%0b back_after=%0b want 0/1", tag, rdy_bad, rdy_back); end
  endtask

  task automatic test_reset();
    reset = 1'b0;
    #1 reset = 1'b1;
    @(negedge clk); @(negedge clk);
    checks++; if (req_ready !== 1'b0) begin failures++; $display("FAIL reset req_ready: got %0b want 0", req_ready); end
    checks++;
    if (fproc_enable !== 1'b0 || fproc_id !== 8'h0 || result_valid !== 1'b0 || result_data !== 32'h0 ||
        result_timeout !== 1'b0 || last_wait !== 16'h0) begin
      failures++;
      $display("FAIL reset outputs: en=%0b id=%0h rv=%0b rd=%0h to=%0b lw=%0d want all 0",
               fproc_enable, fproc_id, result_valid, result_data, result_timeout, last_wait);
    end
    reset = 1'b0;
    #1;
    checks++; if (req_ready !== 1'b1) begin failures++; $display("FAIL reset release req_ready: got %0b want 1", req_ready); end
  endtask

  task automatic test_immediate();
    run_txn(8'd3, 0, 32'h1, 1'b0, "immediate");
  endtask

  task automatic test_delayed();
    run_txn(8'h44, 5, 32'hA5, 1'b0, "delayed");
  endtask

  task automatic test_spurious();
    bit rv_seen, rdy_drop;
    rv_seen = 1'b0; rdy_drop = 1'b0;
    run_txn(8'd7, 0, 32'h1234_5678, 1'b1, "spurious_done");
    for (int c = 0; c < 6; c++) begin
      fproc_ready = 1'(c % 2 == 0); fproc_data = $urandom;
      @(negedge clk);
      if (result_valid) rv_seen = 1'b1;
      if (!req_ready) rdy_drop = 1'b1;
    end
    fproc_ready = 1'b0;
    checks++; if (rv_seen !== 1'b0 || rdy_drop !== 1'b0) begin failures++; $display("FAIL spurious_idle: result_valid_seen=%0b ready_dropped=%0b want 0/0", rv_seen, rdy_drop); end
    checks++; if (result_data !== 32'h1234_5678 || last_wait !== 16'd0) begin failures++; $display("FAIL spurious_idle hold: rd=%0h lw=%0d want 12345678/0", result_data, last_wait); end
  endtask

  task automatic test_reset_mid_wait();
    int n_res;
    n_res = 0;
    run_txn(8'h21, 3, 32'hCAFE_0001, 1'b0, "pre_abort");
    @(negedge clk);
    req_valid = 1'b1; req_id = 8'h5A;
    @(negedge clk);
    req_valid = 1'b0;
    @(negedge clk); @(negedge clk);
    #2 reset = 1'b1;
    #1;
    checks++;
    if (fproc_enable !== 1'b0 || fproc_id !== 8'h0 || result_valid !== 1'b0 || result_data !== 32'h0 ||
        result_timeout !== 1'b0 || last_wait !== 16'h0 || req_ready !== 1'b0) begin
      failures++;
      $display("FAIL abort_reset outputs: en=%0b id=%0h rv=%0b rd=%0h to=%0b lw=%0d rdy=%0b want all 0",
               fproc_enable, fproc_id, result_valid, result_data, result_timeout, last_wait, req_ready);
    end
    @(negedge clk);
    reset = 1'b0;
    fproc_ready = 1'b1; fproc_data = 32'hDEAD_BEEF;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      if (result_valid) n_res++;
    end
    fproc_ready = 1'b0;
    checks++; if (n_res !== 0) begin failures++; $display("FAIL abort no_result: pulses=%0d want 0", n_res); end
    run_txn(8'h6B, 2, 32'h0BAD_F00D, 1'b0, "after_abort");
  endtask

  task automatic test_timeout();
`ifdef FPROC_TIMEOUT_EN
    run_txn(8'h10, 10, 32'h1111_2222, 1'b0, "timeout");
    run_txn(8'h11, TMO, 32'h3333_4444, 1'b0, "ready_on_timeout");
    run_txn(8'h12, TMO - 1, 32'h5555_6666, 1'b0, "ready_before_timeout");
`else
    run_txn(8'h10, 20, 32'h1111_2222, 1'b0, "long_wait");
`endif
  endtask

  task automatic test_back_to_back();
    int n_en, n_res, c1, c2;
    logic [7:0] id1, id2;
    n_en = 0; n_res = 0; c1 = 0; c2 = 0; id1 = '0; id2 = '0;
    @(negedge clk);
    req_valid = 1'b1; req_id = 8'd1; fproc_ready = 1'b1; fproc_data = $urandom;
    for (int c = 1; c <= 9; c++) begin
      @(negedge clk);
      if (fproc_enable) begin
        n_en++;
        if (n_en == 1) begin c1 = c; id1 = fproc_id; req_id = 8'd2; end
        else if (n_en == 2) begin c2 = c; id2 = fproc_id; req_valid = 1'b0; end
      end
      if (result_valid) n_res++;
    end
    req_valid = 1'b0; fproc_ready = 1'b0;
    checks++; if (n_en !== 2 || (c2 - c1) !== 3) begin failures++; $display("FAIL b2b enables: pulses=%0d spacing=%0d want 2/3", n_en, c2 - c1); end
    checks++; if (id1 !== 8'd1 || id2 !== 8'd2) begin failures++; $display("FAIL b2b ids: got %0d,%0d want 1,2", id1, id2); end
    checks++; if (n_res !== 2) begin failures++; $display("FAIL b2b results: pulses=%0d want 2", n_res); end
  endtask

  task automatic test_random();
    for (int i = 0; i < 25; i++) begin
      run_txn(8'($urandom), int'($urandom_range(0, 9)), $urandom, 1'b0, $sformatf("random%0d", i));
    end
  endtask

  initial begin
    test_reset();
    test_immediate();
    test_delayed();
    test_spurious();
    test_reset_mid_wait();
    test_timeout();
    test_back_to_back();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
